// File: rtl/stepper_pkg.sv
// Shared types and default widths for the stepper motion-profile blocks.
package stepper_pkg;

  localparam int STEP_W_DEF   = 16;
  localparam int PERIOD_W_DEF = 24;
  localparam int PULSE_W_DEF  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } ramp_state_t;

endpackage

// File: rtl/step_period_timer.sv
// Loadable down-counter pair: one times the whole step period, the other the
// step high phase. Both strobes are levels that hold once the count hits zero.
module step_period_timer
  import stepper_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int PULSE_W  = PULSE_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [PERIOD_W-1:0] load_val,
  output logic                high_end,
  output logic                period_end
);

  localparam int HW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

  logic [PERIOD_W-1:0] cnt;
  logic [HW-1:0]       hcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      hcnt <= '0;
    end else if (load) begin
      cnt  <= load_val;
      hcnt <= HW'(PULSE_W - 1);
    end else begin
      if (cnt != '0) cnt <= cnt - PERIOD_W'(1);
      if (hcnt != '0) hcnt <= hcnt - HW'(1);
    end
  end

  assign high_end   = (hcnt == '0);
  assign period_end = (cnt == '0);

endmodule

// File: rtl/step_ramp_generator.sv
// Move-command front end for the stepper driver: emits a step/dir pulse train
// whose period ramps linearly from a start interval down to cruise and back.
module step_ramp_generator
  import stepper_pkg::*;
#(
  parameter int STEP_W    = STEP_W_DEF,
  parameter int PERIOD_W  = PERIOD_W_DEF,
  parameter int PULSE_W   = PULSE_W_DEF,
  parameter int DIR_SETUP = 4
) (
  input  logic                clk,
  input  logic                rst,
  // Handshake: a command transfers on the rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready never depends on cmd_valid.
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [STEP_W-1:0]   cmd_steps,
  input  logic                cmd_dir,
  input  logic [PERIOD_W-1:0] cmd_start_period,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic [PERIOD_W-1:0] cmd_accel,
  input  logic                abort,
  output logic                step,
  output logic                dir,
  output logic                busy,
  output logic                done,
  output logic [STEP_W-1:0]   steps_remaining,
  output ramp_state_t         dbg_state
);

  localparam logic [PERIOD_W-1:0] P_MIN      = PERIOD_W'(PULSE_W + 1);
  localparam logic [PERIOD_W-1:0] SETUP_LOAD = PERIOD_W'(DIR_SETUP - 1);

  ramp_state_t         state;
  logic                abort_pend;
  logic [PERIOD_W-1:0] cur, accel_q, p_t_q, p_s_q;
  logic [PERIOD_W-1:0] cmd_p_t, cmd_p_s, cur_next, timer_val, diff, room;
  logic [PERIOD_W:0]   sum_w;
  logic [STEP_W-1:0]   ramp, ramp_next, rem;
  logic                accept, rise, timer_load, high_end, period_end;

  assign cmd_ready = (state == ST_IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign dbg_state = state;

  assign cmd_p_t = (cmd_period > P_MIN) ? cmd_period : P_MIN;
  assign cmd_p_s = (cmd_start_period > cmd_p_t) ? cmd_start_period : cmd_p_t;

  // rise is high when the coming edge issues a step rising edge
  always_comb begin
    rise = 1'b0;
    if (state == ST_SETUP)
      rise = period_end && !abort;
    else if (state == ST_LOW)
      rise = period_end && !abort && !abort_pend && (steps_remaining != '0);
  end

  // A zero-step move loads 0 so the LOW state finishes on the very next edge.
  assign timer_load = accept || rise;
  assign timer_val  = accept ? ((cmd_steps == '0) ? '0 : SETUP_LOAD)
                             : cur - PERIOD_W'(1);

  always_comb begin
    rem       = steps_remaining - STEP_W'(1);
    sum_w     = {1'b0, cur} + {1'b0, accel_q};
    diff      = cur - accel_q;
    room      = cur - p_t_q;
    cur_next  = cur;
    ramp_next = ramp;
    if ((accel_q != '0) && (rem <= ramp) && (ramp != '0)) begin
      cur_next  = (sum_w > {1'b0, p_s_q}) ? p_s_q : sum_w[PERIOD_W-1:0];
      ramp_next = ramp - STEP_W'(1);
    end else if (cur > p_t_q) begin
      cur_next  = (accel_q >= room) ? p_t_q : diff;
      ramp_next = ramp + STEP_W'(1);
    end
  end

  step_period_timer #(
    .PERIOD_W (PERIOD_W),
    .PULSE_W  (PULSE_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load),
    .load_val   (timer_val),
    .high_end   (high_end),
    .period_end (period_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      step            <= 1'b0;
      dir             <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      steps_remaining <= '0;
      abort_pend      <= 1'b0;
      cur             <= '0;
      ramp            <= '0;
      accel_q         <= '0;
      p_t_q           <= '0;
      p_s_q           <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            dir             <= cmd_dir;
            steps_remaining <= cmd_steps;
            busy            <= 1'b1;
            abort_pend      <= 1'b0;
            accel_q         <= cmd_accel;
            p_t_q           <= cmd_p_t;
            p_s_q           <= cmd_p_s;
            cur             <= (cmd_accel == '0) ? cmd_p_t : cmd_p_s;
            ramp            <= '0;
            state           <= (cmd_steps == '0) ? ST_LOW : ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (abort) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (rise) begin
            step            <= 1'b1;
            steps_remaining <= rem;
            cur             <= cur_next;
            ramp            <= ramp_next;
            state           <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          // An abort during the pulse is remembered; the pulse runs to full width.
          abort_pend <= abort_pend || abort;
          if (high_end) begin
            step  <= 1'b0;
            state <= ST_LOW;
          end
        end
        ST_LOW: begin
          if (abort || abort_pend || (period_end && steps_remaining == '0)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (rise) begin
            step            <= 1'b1;
            steps_remaining <= rem;
            cur             <= cur_next;
            ramp            <= ramp_next;
            state           <= ST_HIGH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_step_ramp_generator.sv
// Bench for step_ramp_generator: table of moves with hand-derived rise/done
// cycles, plus sequences for abort, reset mid-move and back-to-back commands.
module tb_step_ramp_generator;
  import stepper_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_steps;
  logic        cmd_dir;
  logic [23:0] cmd_start_period;
  logic [23:0] cmd_period;
  logic [23:0] cmd_accel;
  logic        abort;
  logic        step;
  logic        dir;
  logic        busy;
  logic        done;
  logic [15:0] steps_remaining;
  ramp_state_t dbg_state;

  step_ramp_generator #(
    .STEP_W    (16),
    .PERIOD_W  (24),
    .PULSE_W   (2),
    .DIR_SETUP (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_steps        (cmd_steps),
    .cmd_dir          (cmd_dir),
    .cmd_start_period (cmd_start_period),
    .cmd_period       (cmd_period),
    .cmd_accel        (cmd_accel),
    .abort            (abort),
    .step             (step),
    .dir              (dir),
    .busy             (busy),
    .done             (done),
    .steps_remaining  (steps_remaining),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock / reset bookkeeping ----------------
  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_q = 1'b1;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  typedef struct {
    int   at;
    int   rem;
    logic d;
  } done_exp_t;
  done_exp_t done_q[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic step_prev = 1'b0;
  int   hi_len    = 0;

  always @(negedge clk) begin
    done_exp_t e;
    if (step && !step_prev) begin
      if (exp_q.size() == 0) check("unexpected_rise", cyc, -1);
      else check("rise_cycle", cyc, exp_q.pop_front());
    end
    if (step) hi_len++;
    else if (step_prev) begin
      if (!rst_q) check("pulse_width", hi_len, 2);
      hi_len = 0;
    end
    if (done) begin
      if (done_q.size() == 0) check("unexpected_done", cyc, -1);
      else begin
        e = done_q.pop_front();
        check("done_cycle", cyc, e.at);
        check("done_remaining", steps_remaining, e.rem);
        check("done_dir", dir, e.d);
        check("done_busy_clear", busy, 0);
      end
    end
    step_prev = step;
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [15:0] s, input logic [23:0] st, input logic [23:0] p,
                      input logic [23:0] a, input logic d, output int base);
    int guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) check("ready_timeout", 0, 1);
    cmd_valid        = 1'b1;
    cmd_steps        = s;
    cmd_start_period = st;
    cmd_period       = p;
    cmd_accel        = a;
    cmd_dir          = d;
    base             = cyc + 1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("accept_dir", dir, d);
    check("accept_busy", busy, 1);
  endtask

  // Constant-speed expectation: interval is the period clamped to PULSE_W+1.
  task automatic push_const(input int base, input int s, input int p, input logic d);
    int pe = (p > 3) ? p : 3;
    for (int k = 0; k < s; k++) exp_q.push_back(32'(base + 4 + k * pe));
    if (s == 0) done_q.push_back('{at: base + 1, rem: 0, d: d});
    else done_q.push_back('{at: base + 4 + s * pe, rem: 0, d: d});
  endtask

  task automatic wait_idle(input int limit);
    int g = 0;
    while (done_q.size() != 0 && g < limit) begin
      @(negedge clk);
      g++;
    end
    check("move_complete", done_q.size(), 0);
    check("rises_left", exp_q.size(), 0);
    exp_q.delete();
    done_q.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] steps;
    logic [23:0] start;
    logic [23:0] period;
    logic [23:0] accel;
    logic        d;
    int          nrise;
    int          rise[8];
    int          done_off;
  } vec_t;
  vec_t vec[6];

  initial begin
    int          base;
    int          g;
    logic [15:0] rs;
    logic [23:0] rp, rst_p;
    logic        rd;

    vec[0] = '{16'd3, 24'd0,  24'd10, 24'd0,  1'b1, 3, '{4, 14, 24, 0, 0, 0, 0, 0}, 34};
    vec[1] = '{16'd6, 24'd40, 24'd10, 24'd10, 1'b0, 6, '{4, 44, 74, 94, 104, 124, 0, 0}, 154};
    vec[2] = '{16'd0, 24'd0,  24'd10, 24'd0,  1'b1, 0, '{0, 0, 0, 0, 0, 0, 0, 0}, 1};
    vec[3] = '{16'd2, 24'd0,  24'd1,  24'd0,  1'b0, 2, '{4, 7, 0, 0, 0, 0, 0, 0}, 10};
    vec[4] = '{16'd4, 24'd20, 24'd5,  24'd7,  1'b1, 4, '{4, 24, 37, 43, 0, 0, 0, 0}, 56};
    vec[5] = '{16'd2, 24'd3,  24'd8,  24'd5,  1'b0, 2, '{4, 12, 0, 0, 0, 0, 0, 0}, 20};

    rst              = 1'b1;
    cmd_valid        = 1'b0;
    cmd_steps        = '0;
    cmd_dir          = 1'b0;
    cmd_start_period = '0;
    cmd_period       = '0;
    cmd_accel        = '0;
    abort            = 1'b0;
    repeat (3) @(negedge clk);

    check("reset_step", step, 0);
    check("reset_dir", dir, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_remaining", steps_remaining, 0);
    check("reset_state", dbg_state, ST_IDLE);
    check("ready_in_reset", cmd_ready, 0);
    rst = 1'b0;
    #1;
    check("ready_after_reset", cmd_ready, 1);

    // abort while idle has no effect
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    check("idle_abort_busy", busy, 0);
    check("idle_abort_state", dbg_state, ST_IDLE);

    for (int i = 0; i < 6; i++) begin
      send(vec[i].steps, vec[i].start, vec[i].period, vec[i].accel, vec[i].d, base);
      for (int k = 0; k < vec[i].nrise; k++) exp_q.push_back(32'(base + vec[i].rise[k]));
      done_q.push_back('{at: base + vec[i].done_off, rem: 0, d: vec[i].d});
      wait_idle(400);
    end

    // random constant-speed moves; start period must be ignored when accel is 0
    for (int i = 0; i < 4; i++) begin
      rs    = 16'($urandom_range(1, 4));
      rp    = 24'($urandom_range(1, 12));
      rst_p = 24'($urandom_range(0, 30));
      rd    = 1'($urandom_range(0, 1));
      send(rs, rst_p, rp, 24'd0, rd, base);
      push_const(base, int'(rs), int'(rp), rd);
      wait_idle(200);
    end

    // abort on the 5th rise: full pulse, no 6th rise, 95 steps left
    send(16'd100, 24'd0, 24'd10, 24'd0, 1'b1, base);
    for (int k = 0; k < 5; k++) exp_q.push_back(32'(base + 4 + 10 * k));
    done_q.push_back('{at: base + 47, rem: 95, d: 1'b1});
    g = 0;
    while (cyc != base + 44 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("abort_reached_5th_rise", cyc, base + 44);
    check("abort_step_high", step, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_pulse_kept", step, 1);
    wait_idle(100);
    repeat (30) @(negedge clk);
    check("abort_remaining_held", steps_remaining, 95);
    check("abort_not_busy", busy, 0);

    // back-to-back: second command held valid, accepted in the done cycle
    @(negedge clk);
    cmd_valid        = 1'b1;
    cmd_steps        = 16'd2;
    cmd_start_period = 24'd0;
    cmd_period       = 24'd5;
    cmd_accel        = 24'd0;
    cmd_dir          = 1'b1;
    base             = cyc + 1;
    push_const(base, 2, 5, 1'b1);
    @(negedge clk);
    cmd_steps  = 16'd1;
    cmd_period = 24'd4;
    cmd_dir    = 1'b0;
    g = 0;
    while (!cmd_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("b2b_ready_cycle", cyc, base + 14);
    check("b2b_done_with_ready", done, 1);
    check("b2b_dir_before", dir, 1);
    push_const(cyc + 1, 1, 4, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("b2b_dir_toggle", dir, 0);
    check("b2b_busy", busy, 1);
    wait_idle(100);

    // reset in the middle of a step pulse
    send(16'd10, 24'd0, 24'd10, 24'd0, 1'b1, base);
    push_const(base, 10, 10, 1'b1);
    g = 0;
    while (!step && g < 50) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    check("pre_reset_step_high", step, 1);
    rst = 1'b1;
    exp_q.delete();
    done_q.delete();
    @(negedge clk);
    check("midreset_step", step, 0);
    check("midreset_busy", busy, 0);
    check("midreset_remaining", steps_remaining, 0);
    check("midreset_dir", dir, 0);
    check("midreset_state", dbg_state, ST_IDLE);
    check("midreset_ready_low", cmd_ready, 0);
    rst = 1'b0;
    #1;
    check("midreset_ready_after", cmd_ready, 1);
    repeat (20) @(negedge clk);
    check("midreset_no_step", step, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
